rr_stage_lmsm: RTL and testbench

- Register-read stage of the 6-stage IITB-RISC pipeline. Sits between the ID2RR pipeline register and the RR2EX pipeline register.
- Holds the 8x16 architectural register file, with a synchronous write port from WB and write-to-read bypass.
- Expands LM/SM instructions into one micro-op per set mask bit and stalls upstream stages until the expansion completes.
- All outputs are combinational. The downstream RR2EX register captures them.

---
 rtl/iitb_risc_pkg.sv | 25 ++
 rtl/rr_stage_lmsm_if.sv | 40 ++++
 rtl/regfile_8x16_bypass.sv | 30 +++
 rtl/rr_stage_lmsm.sv | 142 ++++++++++++++
 tb/tb_rr_stage_lmsm.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/iitb_risc_pkg.sv
// rtl/iitb_risc_pkg.sv - shared IITB-RISC constants, micro-op kinds and the LM/SM mask encoder
package iitb_risc_pkg;

  localparam int DATA_W = 16;
  localparam int NREG   = 8;
  localparam int MASK_W = 8;

  localparam logic [3:0] OP_LM = 4'b0110;
  localparam logic [3:0] OP_SM = 4'b0111;

  typedef enum logic [1:0] {
    UOP_NORM = 2'b00,
    UOP_LM   = 2'b01,
    UOP_SM   = 2'b10
  } uop_kind_e;

  // Index of the lowest set bit; 0 when the mask is empty (callers gate on mask != 0).
  function automatic logic [2:0] lowest_set(input logic [MASK_W-1:0] m);
    lowest_set = 3'd0;
    for (int i = MASK_W - 1; i >= 0; i--) begin
      if (m[i]) lowest_set = 3'(i);
    end
  endfunction

endpackage

// File: rtl/rr_stage_lmsm_if.sv
// rtl/rr_stage_lmsm_if.sv - ID2RR/WB inputs and RR2EX micro-op outputs of the register-read stage
interface rr_stage_lmsm_if;
  import iitb_risc_pkg::*;

  logic              enable;
  logic              flush;
  logic              in_valid;
  logic [3:0]        in_opcode;
  logic [2:0]        in_ra;
  logic [2:0]        in_rb;
  logic [MASK_W-1:0] in_mask;
  logic              wb_wr_en;
  logic [2:0]        wb_a3;
  logic [DATA_W-1:0] wb_d3;

  logic              stall_out;
  logic              uop_valid;
  logic [1:0]        uop_kind;
  logic [2:0]        rf_a1_out;
  logic [2:0]        rf_a2_out;
  logic [DATA_W-1:0] rf_d1_out;
  logic [DATA_W-1:0] rf_d2_out;
  logic [2:0]        uop_reg;
  logic [2:0]        uop_offset;

  modport master (
    output enable, flush, in_valid, in_opcode, in_ra, in_rb, in_mask,
    output wb_wr_en, wb_a3, wb_d3,
    input  stall_out, uop_valid, uop_kind, rf_a1_out, rf_a2_out,
    input  rf_d1_out, rf_d2_out, uop_reg, uop_offset
  );

  modport slave (
    input  enable, flush, in_valid, in_opcode, in_ra, in_rb, in_mask,
    input  wb_wr_en, wb_a3, wb_d3,
    output stall_out, uop_valid, uop_kind, rf_a1_out, rf_a2_out,
    output rf_d1_out, rf_d2_out, uop_reg, uop_offset
  );

endinterface

// File: rtl/regfile_8x16_bypass.sv
// rtl/regfile_8x16_bypass.sv - 8x16 register file, one sync write port, two combinational bypassed reads
module regfile_8x16_bypass
  import iitb_risc_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en_i,
  input  logic [2:0]        wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [2:0]        rd_addr1_i,
  input  logic [2:0]        rd_addr2_i,
  output logic [DATA_W-1:0] rd_data1_o,
  output logic [DATA_W-1:0] rd_data2_o
);

  logic [DATA_W-1:0] regs_q [NREG];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (wr_en_i) begin
      regs_q[wr_addr_i] <= wr_data_i;
    end
  end

  // A WB write in the same cycle wins over the stored value.
  assign rd_data1_o = (wr_en_i && (wr_addr_i == rd_addr1_i)) ? wr_data_i : regs_q[rd_addr1_i];
  assign rd_data2_o = (wr_en_i && (wr_addr_i == rd_addr2_i)) ? wr_data_i : regs_q[rd_addr2_i];

endmodule

// File: rtl/rr_stage_lmsm.sv
// rtl/rr_stage_lmsm.sv - register-read stage: register file plus LM/SM expansion into per-register micro-ops
module rr_stage_lmsm
  import iitb_risc_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  rr_stage_lmsm_if.slave bus
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEQ  = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [MASK_W-1:0] rem_mask_q, rem_mask_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] base_q, base_d;
  logic              kind_sm_q, kind_sm_d;

  logic              is_lmsm;
  logic              is_sm;
  logic              in_seq;
  logic [MASK_W-1:0] cur_mask;
  logic [2:0]        elem_b;
  logic [MASK_W-1:0] elem_onehot;
  logic [MASK_W-1:0] mask_left;
  logic [2:0]        rd_a2;
  logic [DATA_W-1:0] rd_d1;
  logic [DATA_W-1:0] rd_d2;

  logic              uop_valid;
  logic              stall;
  uop_kind_e         uop_kind;
  logic [DATA_W-1:0] d1;
  logic [2:0]        uop_reg;
  logic [2:0]        uop_offset;

  assign is_lmsm     = (bus.in_opcode == OP_LM) || (bus.in_opcode == OP_SM);
  assign is_sm       = (bus.in_opcode == OP_SM);
  assign in_seq      = (state_q == ST_SEQ);
  assign cur_mask    = in_seq ? rem_mask_q : bus.in_mask;
  assign elem_b      = lowest_set(cur_mask);
  assign elem_onehot = MASK_W'(1) << elem_b;
  assign mask_left   = cur_mask & ~elem_onehot;
  assign rd_a2       = (in_seq || is_lmsm) ? elem_b : bus.in_rb;

  regfile_8x16_bypass u_rf (
    .clk        (clk),
    .rst        (rst),
    .wr_en_i    (bus.wb_wr_en),
    .wr_addr_i  (bus.wb_a3),
    .wr_data_i  (bus.wb_d3),
    .rd_addr1_i (bus.in_ra),
    .rd_addr2_i (rd_a2),
    .rd_data1_o (rd_d1),
    .rd_data2_o (rd_d2)
  );

  always_comb begin
    state_d    = state_q;
    rem_mask_d = rem_mask_q;
    cnt_d      = cnt_q;
    base_d     = base_q;
    kind_sm_d  = kind_sm_q;
    uop_valid  = 1'b0;
    stall      = 1'b0;
    uop_kind   = UOP_NORM;
    d1         = rd_d1;
    uop_reg    = 3'd0;
    uop_offset = 3'd0;

    if (in_seq) begin
      // ID2RR keeps presenting the LM/SM, so in_ra is still its base register.
      uop_valid  = 1'b1;
      stall      = 1'b1;
      uop_kind   = kind_sm_q ? UOP_SM : UOP_LM;
      d1         = base_q;
      uop_reg    = elem_b;
      uop_offset = cnt_q;
      if (bus.enable) begin
        rem_mask_d = mask_left;
        cnt_d      = cnt_q + 3'd1;
        if (mask_left == '0) state_d = ST_IDLE;
      end
    end else if (bus.in_valid && is_lmsm) begin
      if (bus.in_mask != '0) begin
        uop_valid = 1'b1;
        stall     = (mask_left != '0);
        uop_kind  = is_sm ? UOP_SM : UOP_LM;
        uop_reg   = elem_b;
        if (bus.enable) begin
          base_d     = rd_d1;
          rem_mask_d = mask_left;
          cnt_d      = 3'd1;
          kind_sm_d  = is_sm;
          if (mask_left != '0) state_d = ST_SEQ;
        end
      end
    end else begin
      uop_valid = bus.in_valid;
    end

    if (bus.flush) begin
      uop_valid  = 1'b0;
      stall      = 1'b0;
      state_d    = ST_IDLE;
      rem_mask_d = '0;
      cnt_d      = 3'd0;
    end

    if (rst) begin
      uop_valid = 1'b0;
      stall     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      rem_mask_q <= '0;
      cnt_q      <= 3'd0;
      base_q     <= '0;
      kind_sm_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rem_mask_q <= rem_mask_d;
      cnt_q      <= cnt_d;
      base_q     <= base_d;
      kind_sm_q  <= kind_sm_d;
    end
  end

  assign bus.stall_out  = stall;
  assign bus.uop_valid  = uop_valid;
  assign bus.uop_kind   = uop_kind;
  assign bus.rf_a1_out  = bus.in_ra;
  assign bus.rf_a2_out  = rd_a2;
  assign bus.rf_d1_out  = d1;
  assign bus.rf_d2_out  = rd_d2;
  assign bus.uop_reg    = uop_reg;
  assign bus.uop_offset = uop_offset;

endmodule

// File: tb/tb_rr_stage_lmsm.sv
// tb/tb_rr_stage_lmsm.sv - directed self-checking bench for rr_stage_lmsm
module tb_rr_stage_lmsm;
  import iitb_risc_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  rr_stage_lmsm_if bus ();

  rr_stage_lmsm dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    bus.enable    = 1'b1;
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_opcode = 4'd0;
    bus.in_ra     = 3'd0;
    bus.in_rb     = 3'd0;
    bus.in_mask   = 8'd0;
    bus.wb_wr_en  = 1'b0;
    bus.wb_a3     = 3'd0;
    bus.wb_d3     = 16'd0;
  endtask

  task automatic set_instr(input logic [3:0] op, input logic [2:0] ra, input logic [2:0] rb,
                           input logic [7:0] mask);
    bus.in_valid  = 1'b1;
    bus.in_opcode = op;
    bus.in_ra     = ra;
    bus.in_rb     = rb;
    bus.in_mask   = mask;
  endtask

  task automatic wb_write(input logic [2:0] a, input logic [15:0] d);
    bus.in_valid = 1'b0;
    bus.wb_wr_en = 1'b1;
    bus.wb_a3    = a;
    bus.wb_d3    = d;
    tick();
    bus.wb_wr_en = 1'b0;
  endtask

  task automatic test_reset;
    idle_inputs();
    rst = 1'b1;
    set_instr(OP_LM, 3'd0, 3'd0, 8'hFF);
    #1;
    checks++;
    if ({bus.uop_valid, bus.stall_out} !== 2'b00) begin
      failures++; $display("FAIL reset_outputs got=%b exp=00", {bus.uop_valid, bus.stall_out});
    end
    tick();
    rst = 1'b0;
    set_instr(4'b0000, 3'd0, 3'd5, 8'd0);
    #1;
    checks++;
    if ({bus.uop_valid, bus.rf_d1_out, bus.rf_d2_out} !== {1'b1, 16'h0000, 16'h0000}) begin
      failures++; $display("FAIL reset_regs got=%b/%h/%h exp=1/0000/0000",
                           bus.uop_valid, bus.rf_d1_out, bus.rf_d2_out);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_bypass;
    set_instr(4'b0000, 3'd3, 3'd0, 8'd0);
    bus.wb_wr_en = 1'b1; bus.wb_a3 = 3'd3; bus.wb_d3 = 16'h00AA;
    #1;
    checks++;
    if ({bus.rf_a1_out, bus.rf_d1_out} !== {3'd3, 16'h00AA}) begin
      failures++; $display("FAIL bypass_same_cycle got=%0d/%h exp=3/00aa", bus.rf_a1_out, bus.rf_d1_out);
    end
    tick();
    bus.wb_wr_en = 1'b0;
    #1;
    checks++;
    if (bus.rf_d1_out !== 16'h00AA) begin
      failures++; $display("FAIL bypass_stored got=%h exp=00aa", bus.rf_d1_out);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_add;
    wb_write(3'd1, 16'd5);
    wb_write(3'd2, 16'd9);
    set_instr(4'b0000, 3'd1, 3'd2, 8'd0);
    #1;
    checks++;
    if ({bus.uop_valid, bus.uop_kind, bus.stall_out} !== {1'b1, 2'b00, 1'b0}) begin
      failures++; $display("FAIL add_ctrl got=%b exp=1000", {bus.uop_valid, bus.uop_kind, bus.stall_out});
    end
    checks++;
    if ({bus.rf_d1_out, bus.rf_d2_out, bus.rf_a2_out} !== {16'd5, 16'd9, 3'd2}) begin
      failures++; $display("FAIL add_data got=%h/%h/%0d exp=0005/0009/2",
                           bus.rf_d1_out, bus.rf_d2_out, bus.rf_a2_out);
    end
    checks++;
    if ({bus.uop_reg, bus.uop_offset} !== 6'd0) begin
      failures++; $display("FAIL add_elem got=%0d/%0d exp=0/0", bus.uop_reg, bus.uop_offset);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_lm;
    logic [2:0]  exp_reg [4];
    logic [15:0] exp_d2 [4];
    exp_reg = '{3'd1, 3'd2, 3'd4, 3'd7};
    exp_d2  = '{16'd5, 16'd9, 16'd0, 16'd0};
    wb_write(3'd0, 16'h0100);
    set_instr(OP_LM, 3'd0, 3'd0, 8'b1001_0110);
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if ({bus.uop_valid, bus.uop_kind, bus.stall_out} !== {1'b1, 2'b01, 1'b1}) begin
        failures++; $display("FAIL lm_ctrl[%0d] got=%b exp=1011", i,
                             {bus.uop_valid, bus.uop_kind, bus.stall_out});
      end
      checks++;
      if ({bus.uop_reg, bus.rf_a2_out, bus.uop_offset} !== {exp_reg[i], exp_reg[i], 3'(i)}) begin
        failures++; $display("FAIL lm_elem[%0d] got=%0d/%0d/%0d exp=%0d/%0d/%0d", i, bus.uop_reg,
                             bus.rf_a2_out, bus.uop_offset, exp_reg[i], exp_reg[i], i);
      end
      checks++;
      if ({bus.rf_d1_out, bus.rf_d2_out} !== {16'h0100, exp_d2[i]}) begin
        failures++; $display("FAIL lm_data[%0d] got=%h/%h exp=0100/%h", i,
                             bus.rf_d1_out, bus.rf_d2_out, exp_d2[i]);
      end
      tick();
    end
    bus.in_valid = 1'b0;
    #1;
    checks++;
    if ({bus.uop_valid, bus.stall_out} !== 2'b00) begin
      failures++; $display("FAIL lm_done got=%b exp=00", {bus.uop_valid, bus.stall_out});
    end
    idle_inputs();
  endtask

  task automatic test_lm_base;
    wb_write(3'd2, 16'h0222);
    set_instr(OP_LM, 3'd2, 3'd0, 8'b0000_0101);
    #1;
    checks++;
    if ({bus.uop_reg, bus.uop_offset, bus.stall_out, bus.rf_d1_out, bus.rf_d2_out}
        !== {3'd0, 3'd0, 1'b1, 16'h0222, 16'h0100}) begin
      failures++; $display("FAIL lm_base_e0 got=%0d/%0d/%b/%h/%h exp=0/0/1/0222/0100", bus.uop_reg,
                           bus.uop_offset, bus.stall_out, bus.rf_d1_out, bus.rf_d2_out);
    end
    tick();
    bus.wb_wr_en = 1'b1; bus.wb_a3 = 3'd2; bus.wb_d3 = 16'h0999;
    #1;
    checks++;
    if ({bus.uop_reg, bus.uop_offset, bus.stall_out, bus.rf_d1_out, bus.rf_d2_out}
        !== {3'd2, 3'd1, 1'b1, 16'h0222, 16'h0999}) begin
      failures++; $display("FAIL lm_base_e1 got=%0d/%0d/%b/%h/%h exp=2/1/1/0222/0999", bus.uop_reg,
                           bus.uop_offset, bus.stall_out, bus.rf_d1_out, bus.rf_d2_out);
    end
    tick();
    idle_inputs();
    #1;
    checks++;
    if (bus.stall_out !== 1'b0) begin
      failures++; $display("FAIL lm_base_done got=%b exp=0", bus.stall_out);
    end
  endtask

  task automatic test_sm_enable;
    set_instr(OP_SM, 3'd1, 3'd0, 8'b0000_0011);
    #1;
    checks++;
    if ({bus.uop_valid, bus.uop_kind, bus.stall_out, bus.uop_reg, bus.uop_offset, bus.rf_d1_out,
         bus.rf_d2_out} !== {1'b1, 2'b10, 1'b1, 3'd0, 3'd0, 16'd5, 16'h0100}) begin
      failures++; $display("FAIL sm_e0 got=%b/%0d/%0d/%h/%h exp=1101/0/0/0005/0100",
                           {bus.uop_valid, bus.uop_kind, bus.stall_out}, bus.uop_reg,
                           bus.uop_offset, bus.rf_d1_out, bus.rf_d2_out);
    end
    tick();
    bus.enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) bus.enable = 1'b1;
      #1;
      checks++;
      if ({bus.uop_valid, bus.uop_kind, bus.stall_out, bus.uop_reg, bus.uop_offset, bus.rf_d1_out,
           bus.rf_d2_out} !== {1'b1, 2'b10, 1'b1, 3'd1, 3'd1, 16'd5, 16'd5}) begin
        failures++; $display("FAIL sm_e1[%0d] got=%b/%0d/%0d/%h/%h exp=1101/1/1/0005/0005", i,
                             {bus.uop_valid, bus.uop_kind, bus.stall_out}, bus.uop_reg,
                             bus.uop_offset, bus.rf_d1_out, bus.rf_d2_out);
      end
      tick();
    end
    bus.in_valid = 1'b0;
    #1;
    checks++;
    if ({bus.uop_valid, bus.stall_out} !== 2'b00) begin
      failures++; $display("FAIL sm_done got=%b exp=00", {bus.uop_valid, bus.stall_out});
    end
    idle_inputs();
  endtask

  task automatic test_flush;
    set_instr(OP_LM, 3'd0, 3'd0, 8'b0000_1110);
    #1;
    checks++;
    if ({bus.uop_reg, bus.stall_out} !== {3'd1, 1'b1}) begin
      failures++; $display("FAIL flush_e0 got=%0d/%b exp=1/1", bus.uop_reg, bus.stall_out);
    end
    tick();
    bus.flush = 1'b1;
    #1;
    checks++;
    if ({bus.uop_valid, bus.stall_out} !== 2'b00) begin
      failures++; $display("FAIL flush_same got=%b exp=00", {bus.uop_valid, bus.stall_out});
    end
    tick();
    bus.flush = 1'b0;
    set_instr(4'b0000, 3'd1, 3'd2, 8'd0);
    #1;
    checks++;
    if ({bus.uop_valid, bus.uop_kind, bus.stall_out, bus.rf_d1_out, bus.rf_d2_out}
        !== {1'b1, 2'b00, 1'b0, 16'd5, 16'h0999}) begin
      failures++; $display("FAIL flush_next got=%b/%h/%h exp=1000/0005/0999",
                           {bus.uop_valid, bus.uop_kind, bus.stall_out}, bus.rf_d1_out, bus.rf_d2_out);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_bubble;
    set_instr(OP_SM, 3'd1, 3'd0, 8'd0);
    #1;
    checks++;
    if ({bus.uop_valid, bus.stall_out} !== 2'b00) begin
      failures++; $display("FAIL bubble got=%b exp=00", {bus.uop_valid, bus.stall_out});
    end
    tick();
    set_instr(4'b0001, 3'd1, 3'd2, 8'd0);
    #1;
    checks++;
    if ({bus.uop_valid, bus.uop_kind, bus.stall_out} !== {1'b1, 2'b00, 1'b0}) begin
      failures++; $display("FAIL bubble_next got=%b exp=1000", {bus.uop_valid, bus.uop_kind, bus.stall_out});
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_rst_mid;
    set_instr(OP_LM, 3'd0, 3'd0, 8'b0000_1110);
    tick();
    #1;
    checks++;
    if ({bus.stall_out, bus.uop_offset} !== {1'b1, 3'd1}) begin
      failures++; $display("FAIL rst_mid_seq got=%b/%0d exp=1/1", bus.stall_out, bus.uop_offset);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.uop_valid, bus.stall_out} !== 2'b00) begin
      failures++; $display("FAIL rst_mid_out got=%b exp=00", {bus.uop_valid, bus.stall_out});
    end
    tick();
    rst = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    checks++;
    if (bus.stall_out !== 1'b0) begin
      failures++; $display("FAIL rst_mid_idle got=%b exp=0", bus.stall_out);
    end
    set_instr(4'b0000, 3'd1, 3'd2, 8'd0);
    #1;
    checks++;
    if ({bus.uop_valid, bus.rf_d1_out, bus.rf_d2_out} !== {1'b1, 16'd0, 16'd0}) begin
      failures++; $display("FAIL rst_mid_regs got=%b/%h/%h exp=1/0000/0000",
                           bus.uop_valid, bus.rf_d1_out, bus.rf_d2_out);
    end
    tick();
    idle_inputs();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    idle_inputs();
    tick();
    tick();
    test_reset();
    test_bypass();
    test_add();
    test_lm();
    test_lm_base();
    test_sm_enable();
    test_flush();
    test_bubble();
    test_rst_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
